// File: rtl/input_debouncer_pkg.sv
// debounce_pkg: shared state encoding and parameter defaults for input_debouncer.
package debounce_pkg;
    typedef enum logic [1:0] {ST_LOW, ST_QUAL_HI, ST_HIGH, ST_QUAL_LO} deb_state_t;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int STABLE_CYCLES_DEF = 16;
endpackage

// File: rtl/input_debouncer_sync_chain.sv
// sync_chain: multi-flop synchronizer for one asynchronous bit, resets to 0.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] ff;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) ff <= '0;
        else ff <= {ff[SYNC_STAGES-2:0], d};
    assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes a bouncy input and commits level changes after STABLE_CYCLES stable samples.
// Optional glitch counter port enabled by DEBOUNCE_GLITCH_CNT_EN.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    parameter int GLITCH_W = 8
`endif
) (
    input  logic clk,
    input  logic resetn,
    input  logic din_raw,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic dout,
    output logic busy
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    logic sync_q;
    deb_state_t state;
    logic [CW-1:0] cnt;
    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .resetn(resetn),
        .d(din_raw),
        .q(sync_q)
    );
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= ST_LOW;
            cnt <= '0;
            dout <= 1'b0;
            busy <= 1'b0;
        end else begin
            case (state)
                ST_LOW:
                    if (sync_q) begin
                        state <= ST_QUAL_HI;
                        cnt <= CW'(1);
                        busy <= 1'b1;
                    end
                ST_QUAL_HI:
                    if (!sync_q) begin
                        state <= ST_LOW;
                        cnt <= '0;
                        busy <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ST_HIGH;
                        dout <= 1'b1;
                        cnt <= '0;
                        busy <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                ST_HIGH:
                    if (!sync_q) begin
                        state <= ST_QUAL_LO;
                        cnt <= CW'(1);
                        busy <= 1'b1;
                    end
                ST_QUAL_LO:
                    if (sync_q) begin
                        state <= ST_HIGH;
                        cnt <= '0;
                        busy <= 1'b0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ST_LOW;
                        dout <= 1'b0;
                        cnt <= '0;
                        busy <= 1'b0;
                    end else cnt <= cnt + 1'b1;
                default: begin
                    state <= ST_LOW;
                    cnt <= '0;
                    busy <= 1'b0;
                end
            endcase
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    // a failed qualification is a candidate reversing before commit
    logic glitch;
    assign glitch = (state == ST_QUAL_HI && !sync_q) || (state == ST_QUAL_LO && sync_q);
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) glitch_cnt <= '0;
        else if (glitch && glitch_cnt != '1) glitch_cnt <= glitch_cnt + 1'b1;
`endif
endmodule
